// File: rtl/bip_control.sv
// Control unit for the BIP accumulator CPU: runs fetch/execute over program memory and drives the datapath strobes.
// Define BIP_CONTROL_CYCLE_CNT_EN to build a saturating executed-instruction counter on o_cycle_cnt.
module bip_control #(
    parameter int N_BUS    = 16,
    parameter int N_BUS_IN = 11,
    parameter int N_OPCODE = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [N_BUS-1:0]    i_instr,
    output logic [N_BUS_IN-1:0] o_pc_addr,
    output logic [N_BUS_IN-1:0] o_signal,
    output logic [1:0]          o_selA,
    output logic                o_selB,
    output logic                o_WrAcc,
    output logic                o_OP,
    output logic                o_WrRam,
    output logic                o_RdRam,
    output logic                o_halt,
    output logic [15:0]         o_cycle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [N_OPCODE-1:0] OP_HLT  = N_OPCODE'(0);
    localparam logic [N_OPCODE-1:0] OP_STO  = N_OPCODE'(1);
    localparam logic [N_OPCODE-1:0] OP_LD   = N_OPCODE'(2);
    localparam logic [N_OPCODE-1:0] OP_LDI  = N_OPCODE'(3);
    localparam logic [N_OPCODE-1:0] OP_ADD  = N_OPCODE'(4);
    localparam logic [N_OPCODE-1:0] OP_ADDI = N_OPCODE'(5);
    localparam logic [N_OPCODE-1:0] OP_SUB  = N_OPCODE'(6);
    localparam logic [N_OPCODE-1:0] OP_SUBI = N_OPCODE'(7);

    state_t              state_q;
    logic [N_BUS_IN-1:0] pc_q;
    logic [N_BUS-1:0]    ir_q;
    logic [1:0]          sel_a_q;
    logic                sel_b_q, wr_acc_q, op_q, wr_ram_q, rd_ram_q, halt_q;

    logic [N_OPCODE-1:0] fetch_opcode;
    logic [1:0]          sel_a_d;
    logic                sel_b_d, wr_acc_d, op_d, wr_ram_d, rd_ram_d;

    // Strobes are decoded from the word being fetched so they are registered
    // exactly in the EXEC cycle that follows.
    assign fetch_opcode = i_instr[N_BUS-1 -: N_OPCODE];

    always_comb begin
        sel_a_d  = 2'b00;
        sel_b_d  = 1'b0;
        wr_acc_d = 1'b0;
        op_d     = 1'b0;
        wr_ram_d = 1'b0;
        rd_ram_d = 1'b0;
        case (fetch_opcode)
            OP_STO: wr_ram_d = 1'b1;
            OP_LD: begin
                rd_ram_d = 1'b1;
                wr_acc_d = 1'b1;
            end
            OP_LDI: begin
                sel_a_d  = 2'b01;
                wr_acc_d = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                rd_ram_d = 1'b1;
                sel_a_d  = 2'b10;
                wr_acc_d = 1'b1;
                op_d     = (fetch_opcode == OP_SUB);
            end
            OP_ADDI, OP_SUBI: begin
                sel_b_d  = 1'b1;
                sel_a_d  = 2'b10;
                wr_acc_d = 1'b1;
                op_d     = (fetch_opcode == OP_SUBI);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            sel_a_q  <= 2'b00;
            sel_b_q  <= 1'b0;
            wr_acc_q <= 1'b0;
            op_q     <= 1'b0;
            wr_ram_q <= 1'b0;
            rd_ram_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            sel_a_q  <= 2'b00;
            sel_b_q  <= 1'b0;
            wr_acc_q <= 1'b0;
            op_q     <= 1'b0;
            wr_ram_q <= 1'b0;
            rd_ram_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    ir_q     <= i_instr;
                    sel_a_q  <= sel_a_d;
                    sel_b_q  <= sel_b_d;
                    wr_acc_q <= wr_acc_d;
                    op_q     <= op_d;
                    wr_ram_q <= wr_ram_d;
                    rd_ram_q <= rd_ram_d;
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (ir_q[N_BUS-1 -: N_OPCODE] == OP_HLT) begin
                        state_q <= ST_HALT;
                        halt_q  <= 1'b1;
                    end else begin
                        pc_q    <= pc_q + 1'b1;  // wraps naturally at the top of memory
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

`ifdef BIP_CONTROL_CYCLE_CNT_EN
    logic [15:0] cycle_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle_cnt_q <= '0;
        end else if (state_q == ST_EXEC && cycle_cnt_q != 16'hFFFF) begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
        end
    end

    assign o_cycle_cnt = cycle_cnt_q;
`else
    assign o_cycle_cnt = 16'd0;
`endif

    assign o_pc_addr = pc_q;
    assign o_signal  = ir_q[N_BUS_IN-1:0];
    assign o_selA    = sel_a_q;
    assign o_selB    = sel_b_q;
    assign o_WrAcc   = wr_acc_q;
    assign o_OP      = op_q;
    assign o_WrRam   = wr_ram_q;
    assign o_RdRam   = rd_ram_q;
    assign o_halt    = halt_q;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: a decode vector table plus hand-written program, wrap and reset sequences.
module tb_bip_control;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [15:0] i_instr;
    logic [10:0] o_pc_addr;
    logic [10:0] o_signal;
    logic [1:0]  o_selA;
    logic        o_selB, o_WrAcc, o_OP, o_WrRam, o_RdRam, o_halt;
    logic [15:0] o_cycle_cnt;

    logic [15:0] prog [0:2047];
    logic [6:0]  ctrl;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BIP_CONTROL_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    bip_control dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_instr    (i_instr),
        .o_pc_addr  (o_pc_addr),
        .o_signal   (o_signal),
        .o_selA     (o_selA),
        .o_selB     (o_selB),
        .o_WrAcc    (o_WrAcc),
        .o_OP       (o_OP),
        .o_WrRam    (o_WrRam),
        .o_RdRam    (o_RdRam),
        .o_halt     (o_halt),
        .o_cycle_cnt(o_cycle_cnt)
    );

    always #5 i_clk = ~i_clk;

    assign i_instr = prog[o_pc_addr];
    // {selA, selB, WrAcc, OP, WrRam, RdRam}
    assign ctrl = {o_selA, o_selB, o_WrAcc, o_OP, o_WrRam, o_RdRam};

    typedef struct packed {
        logic [4:0]  op;
        logic [10:0] opr;
        logic [6:0]  ctrl;
        logic        hlt;
    } vec_t;

    vec_t vecs [0:9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_prog(input logic [15:0] w);
        for (int a = 0; a < 2048; a++) prog[a] = w;
    endtask

    task automatic do_reset();
        i_start = 1'b0;
        i_rst_n = 1'b0;
        #2;
        chk("reset_outputs", {o_pc_addr, o_signal, ctrl, o_halt}, 32'd0);
        chk("reset_cnt", {16'd0, o_cycle_cnt}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Returns at the negedge while the FSM is in FETCH of the first instruction.
    task automatic start_pulse();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        fill_prog(16'h0000);

        vecs[0] = '{5'b00000, 11'h000, 7'b00_0_0_0_0_0, 1'b1};  // HLT
        vecs[1] = '{5'b00001, 11'h010, 7'b00_0_0_0_1_0, 1'b0};  // STO
        vecs[2] = '{5'b00010, 11'h7FF, 7'b00_0_1_0_0_1, 1'b0};  // LD
        vecs[3] = '{5'b00011, 11'h005, 7'b01_0_1_0_0_0, 1'b0};  // LDI
        vecs[4] = '{5'b00100, 11'h123, 7'b10_0_1_0_0_1, 1'b0};  // ADD
        vecs[5] = '{5'b00101, 11'h003, 7'b10_1_1_0_0_0, 1'b0};  // ADDI
        vecs[6] = '{5'b00110, 11'h7FF, 7'b10_0_1_1_0_1, 1'b0};  // SUB
        vecs[7] = '{5'b00111, 11'h400, 7'b10_1_1_1_0_0, 1'b0};  // SUBI
        vecs[8] = '{5'b01011, 11'h055, 7'b00_0_0_0_0_0, 1'b0};  // NOP
        vecs[9] = '{5'b11111, 11'h2AA, 7'b00_0_0_0_0_0, 1'b0};  // NOP

        // Single-instruction decode table, each followed by HLT.
        for (int v = 0; v < 10; v++) begin
            fill_prog(16'h0000);
            prog[0] = {vecs[v].op, vecs[v].opr};
            do_reset();
            start_pulse();
            @(negedge i_clk);  // EXEC
            chk($sformatf("v%0d_exec_ctrl", v), {25'd0, ctrl}, {25'd0, vecs[v].ctrl});
            chk($sformatf("v%0d_exec_sig", v), {21'd0, o_signal}, {21'd0, vecs[v].opr});
            @(negedge i_clk);  // FETCH of next word, or HALT
            chk($sformatf("v%0d_after", v), {12'd0, o_pc_addr, ctrl, o_halt},
                {12'd0, (vecs[v].hlt ? 11'd0 : 11'd1), 7'd0, vecs[v].hlt});
            chk($sformatf("v%0d_cnt", v), {16'd0, o_cycle_cnt}, {31'd0, CNT_EN});
            $display("vector %0d opcode %b operand 0x%03h done", v, vecs[v].op, vecs[v].opr);
        end

        // Program LDI 5, ADDI 3, STO 0x010, HLT; i_start held high once halted.
        begin
            logic [6:0]  pc_ctrl [0:3];
            logic [10:0] pc_sig  [0:3];
            pc_ctrl[0] = 7'b01_0_1_0_0_0; pc_sig[0] = 11'h005;
            pc_ctrl[1] = 7'b10_1_1_0_0_0; pc_sig[1] = 11'h003;
            pc_ctrl[2] = 7'b00_0_0_0_1_0; pc_sig[2] = 11'h010;
            pc_ctrl[3] = 7'b00_0_0_0_0_0; pc_sig[3] = 11'h000;
            fill_prog(16'h0000);
            prog[0] = {5'b00011, 11'h005};
            prog[1] = {5'b00101, 11'h003};
            prog[2] = {5'b00001, 11'h010};
            prog[3] = {5'b00000, 11'h000};
            do_reset();
            start_pulse();
            for (int k = 0; k < 4; k++) begin
                @(negedge i_clk);
                chk($sformatf("prog_exec%0d", k), {o_pc_addr, o_signal, ctrl, o_halt},
                    {11'(k), pc_sig[k], pc_ctrl[k], 1'b0});
                @(negedge i_clk);
                if (k < 3) chk($sformatf("prog_fetch%0d", k), {21'd0, ctrl, o_halt}, 32'd0);
            end
            chk("prog_halt", {20'd0, o_pc_addr, o_halt}, {20'd0, 11'd3, 1'b1});
            chk("prog_cnt", {16'd0, o_cycle_cnt}, CNT_EN ? 32'd4 : 32'd0);
            i_start = 1'b1;
            repeat (5) @(negedge i_clk);
            chk("halt_start_ignored", {o_pc_addr, ctrl, o_halt}, {11'd3, 7'd0, 1'b1});
            i_start = 1'b0;
            $display("program LDI/ADDI/STO/HLT done");
        end

        // NOP program with opcode 01011 at PC=2, running through the PC wrap.
        begin
            int budget;
            fill_prog({5'b01000, 11'h000});
            prog[2] = {5'b01011, 11'h0AA};
            do_reset();
            start_pulse();
            budget = 0;
            while (o_pc_addr != 11'd2 && budget < 20) begin
                @(negedge i_clk);
                budget++;
            end
            chk("reach_pc2", {31'd0, (budget < 20)}, 32'd1);
            @(negedge i_clk);
            chk("pc2_exec", {o_pc_addr, o_signal, ctrl}, {11'd2, 11'h0AA, 7'd0});
            @(negedge i_clk);
            chk("pc2_next", {21'd0, o_pc_addr}, 32'd3);
            budget = 0;
            while (o_pc_addr != 11'h7FE && budget < 5000) begin
                @(negedge i_clk);
                budget++;
            end
            chk("reach_7fe", {31'd0, (budget < 5000)}, 32'd1);
            @(negedge i_clk);
            chk("wrap_exec_7fe", {21'd0, o_pc_addr}, 32'h7FE);
            repeat (2) @(negedge i_clk);
            chk("wrap_exec_7ff", {21'd0, o_pc_addr}, 32'h7FF);
            repeat (2) @(negedge i_clk);
            chk("wrap_exec_000", {o_pc_addr, ctrl, o_halt}, {11'd0, 7'd0, 1'b0});
            chk("wrap_cnt", {16'd0, o_cycle_cnt}, CNT_EN ? 32'h800 : 32'd0);
            $display("wrap sequence done");
        end

        // Reset asserted in the middle of an ADD EXEC cycle.
        fill_prog(16'h0000);
        prog[0] = {5'b00100, 11'h020};
        do_reset();
        start_pulse();
        @(negedge i_clk);
        chk("add_exec_wracc", {31'd0, o_WrAcc}, 32'd1);
        #1 i_rst_n = 1'b0;
        #1;
        chk("abort_immediate", {o_pc_addr, o_signal, ctrl, o_halt}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        chk("idle_after_reset", {o_pc_addr, ctrl, o_halt}, 32'd0);
        $display("mid-EXEC reset done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
